// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed BCD 7-segment scanner with frame-synchronous shadow swap.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [IW-1:0]         digit_idx,
    output logic                  frame_tick
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    logic [PW-1:0]       presc;
    logic [4*DIGITS-1:0] sh_bcd, act_bcd;
    logic [DIGITS-1:0]   sh_dp, sh_blank, act_dp, act_blank;
    logic                pending;
    logic                slot_end, swap, cur_dark;
    logic [3:0]          cur_code;
    logic [7:0]          cur_seg;
    logic [DIGITS-1:0]   an_hot;

    assign slot_end = enable && (presc == PW'(CLK_DIV - 1));
    assign swap     = slot_end && (digit_idx == IW'(DIGITS - 1));
    assign cur_code = act_bcd[4*digit_idx +: 4];
    assign an_hot   = DIGITS'(1) << digit_idx;
    assign cur_seg  = cur_dark ? 8'h00 : {act_dp[digit_idx], decode(cur_code)};

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] lzb_next, act_mask;
    logic              run;
    // Mask is computed from the shadow word so it lands in the same swap as the data.
    always_comb begin
        lzb_next = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run = run && (sh_bcd[4*i +: 4] == 4'd0) && !sh_dp[i];
            lzb_next[i] = run;
        end
    end
    assign cur_dark = act_blank[digit_idx] || act_mask[digit_idx];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            act_mask <= '0;
        else if (swap && pending)
            act_mask <= lzb_next;
`else
    assign cur_dark = act_blank[digit_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
            sh_bcd     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            pending    <= 1'b0;
            act_bcd    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
        end else begin
            presc      <= (!enable || slot_end) ? '0 : presc + 1'b1;
            digit_idx  <= (!enable || swap) ? '0 : slot_end ? digit_idx + 1'b1 : digit_idx;
            frame_tick <= swap;
            if (load) begin
                sh_bcd   <= bcd_in;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
            end
            // A load coinciding with the swap keeps pending set for the following frame.
            pending <= load || (pending && !swap);
            if (swap && pending) begin
                act_bcd   <= sh_bcd;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
            end
            seg <= enable ? (cur_seg ^ SEG_OFF) : SEG_OFF;
            an  <= enable ? (an_hot ^ AN_OFF) : AN_OFF;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed plus randomized checks of seg7_scan_driver against a cycle-count model.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int passed = 0, total = 0, fails = 0;

    // Model: n = enabled clock edges since last disable/reset; digit = (n/4)%4, wrap when n%16==0.
    int          n = 0;
    logic [15:0] m_sb = '0, m_ab = '0;
    logic [3:0]  m_sd = '0, m_sbk = '0, m_ad = '0, m_abk = '0, m_mask = '0;
    bit          m_pend = 0;
    logic [7:0]  tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in),
        .dp_in(dp_in), .blank_in(blank_in), .seg(seg), .an(an),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lzb(input logic [15:0] b, input logic [3:0] d);
        logic [3:0] m = '0;
`ifdef SEG7_LZB_EN
        for (int i = 3; i > 0; i--) begin
            if (b[4*i +: 4] != 4'd0 || d[i]) break;
            m[i] = 1'b1;
        end
`endif
        return m;
    endfunction

    function automatic logic [7:0] segbyte(input int i);
        logic [7:0] t;
        t = tbl[m_ab[4*i +: 4]];
        return (m_abk[i] || m_mask[i]) ? 8'h00 : {m_ad[i], t[6:0]};
    endfunction

    task automatic model_reset();
        n = 0; m_sb = '0; m_ab = '0; m_sd = '0; m_sbk = '0;
        m_ad = '0; m_abk = '0; m_mask = '0; m_pend = 0;
    endtask

    task automatic tick();
        int idx;
        logic [7:0] es;
        logic [3:0] ea;
        bit et;
        idx = (n / 4) % 4;
        es = enable ? segbyte(idx) : 8'h00;
        ea = enable ? ~4'(4'b0001 << idx) : 4'hF;
        et = 0;
        if (enable) begin
            n++;
            et = (n % 16) == 0;
            if (et && m_pend) begin
                m_ab = m_sb; m_ad = m_sd; m_abk = m_sbk;
                m_mask = lzb(m_sb, m_sd);
                m_pend = 0;
            end
        end else n = 0;
        if (load) begin
            m_sb = bcd_in; m_sd = dp_in; m_sbk = blank_in; m_pend = 1;
        end
        @(posedge clk);
        #1;
        chk("seg", seg, es);
        chk("an", an, ea);
        chk("digit_idx", digit_idx, (n / 4) % 4);
        chk("frame_tick", frame_tick, et);
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] k);
        bcd_in = b; dp_in = d; blank_in = k; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        #12;
        chk("reset_seg", seg, 8'h00);
        chk("reset_an", an, 4'hF);
        chk("reset_idx", digit_idx, 0);
        chk("reset_tick", frame_tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        run(5);
        do_load(16'h1234, 4'b0000, 4'b0000);
        run(40);
        do_load(16'h00A5, 4'b0010, 4'b0000);
        run(32);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an == 4'b1101) chk("digit1_dp_dash", seg, 8'hC0);
            if (an == 4'b1110) chk("digit0_five", seg, 8'h6D);
`ifdef SEG7_LZB_EN
            if (an == 4'b0111) chk("digit3_lzb", seg, 8'h00);
`else
            if (an == 4'b0111) chk("digit3_zero", seg, 8'h3F);
`endif
        end
        do_load(16'h1111, 4'b0000, 4'b0000);
        run(2);
        do_load(16'h2222, 4'b0000, 4'b0000);
        run(20);
        while ((n % 16) != 15) tick();
        do_load(16'h9876, 4'b1000, 4'b0000);
        run(36);
        run(6);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        do_load(16'h4321, 4'b0000, 4'b0100);
        run(40);
        for (int i = 0; i < 500; i++) begin
            enable = $urandom_range(0, 19) != 0;
            load = $urandom_range(0, 5) == 0;
            bcd_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
            dp_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            tick();
        end
        load = 1'b0;
        enable = 1'b1;
        run(7);
        #2 rst_n = 1'b0;
        #1;
        chk("midscan_reset_seg", seg, 8'h00);
        chk("midscan_reset_an", an, 4'hF);
        chk("midscan_reset_idx", digit_idx, 0);
        chk("midscan_reset_tick", frame_tick, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(20);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
